// File: rtl/regfile_pkg.sv
// Shared constants, types and helpers for the multi-port LEGv8 register file.
package regfile_pkg;

    localparam int DEFAULT_DATA_W   = 64;
    localparam int DEFAULT_NUM_REGS = 32;
    localparam int XZR_IDX          = DEFAULT_NUM_REGS - 1;

    typedef logic [4:0] reg_idx_t;

    // Ceiling log2, usable in constant expressions for address widths.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Bus bundle between decode/writeback (master) and the register file (slave).
interface regfile_mp_if
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int NUM_REGS = DEFAULT_NUM_REGS,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 1
);

    localparam int AW = clog2(NUM_REGS);

    logic [NUM_WR-1:0]        wr_en;
    logic [NUM_WR*AW-1:0]     wr_addr;
    logic [NUM_WR*DATA_W-1:0] wr_data;
    logic [NUM_RD-1:0]        rd_en;
    logic [NUM_RD*AW-1:0]     rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic                     busy_set;
    logic [AW-1:0]            busy_addr;

    modport master (
        output wr_en, wr_addr, wr_data, rd_en, rd_addr, busy_set, busy_addr,
        input  rd_data, rd_busy
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_en, rd_addr, busy_set, busy_addr,
        output rd_data, rd_busy
    );

endinterface

// File: rtl/regfile_bypass_mux.sv
// Resolves one read: zero register first, then the highest-priority
// same-edge write to the address, else the stored value.
module regfile_bypass_mux
    import regfile_pkg::*;
#(
    parameter int W        = DEFAULT_DATA_W,
    parameter int AW       = 5,
    parameter int NP       = 1,
    parameter int ZERO_IDX = XZR_IDX
) (
    input  logic [AW-1:0]   rd_addr,
    input  logic [NP-1:0]   wr_en,
    input  logic [NP*AW-1:0] wr_addr,
    input  logic [NP*W-1:0] wr_data,
    input  logic [W-1:0]    arr_val,
    output logic [W-1:0]    val
);

    // Later ports override earlier ones; the zero index overrides everything.
    always_comb begin
        val = arr_val;
        for (int k = 0; k < NP; k++) begin
            if (wr_en[k] && (wr_addr[k*AW +: AW] == rd_addr)) begin
                val = wr_data[k*W +: W];
            end
        end
        if (rd_addr == AW'(ZERO_IDX)) begin
            val = '0;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: synchronous writes, registered write-first
// reads, hardwired zero register at the top index, per-register busy bits.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W      = DEFAULT_DATA_W,
    parameter int NUM_REGS    = DEFAULT_NUM_REGS,
    parameter int NUM_RD      = 2,
    parameter int NUM_WR      = 1,
    parameter int RESET_INDEX = 1
) (
    input logic         clk,
    input logic         rst_n,
    regfile_mp_if.slave bus
);

    localparam int            AW        = clog2(NUM_REGS);
    localparam int            ZERO_IDX  = NUM_REGS - 1;
    localparam logic [AW-1:0] ZERO_ADDR = AW'(ZERO_IDX);

    logic [DATA_W-1:0]        mem_q [NUM_REGS];
    logic [DATA_W-1:0]        mem_d [NUM_REGS];
    logic [NUM_REGS-1:0]      busy_q, busy_d;
    logic [NUM_RD*DATA_W-1:0] rd_data_q, rd_data_d;
    logic [NUM_RD-1:0]        rd_busy_q, rd_busy_d;

    logic [DATA_W-1:0]        byp_data [NUM_RD];
    logic                     byp_busy [NUM_RD];

    // Busy updates look like extra write ports: writes carry 0, the load
    // marker is appended last so it takes priority over a retiring write.
    logic [NUM_WR:0]          bsy_en;
    logic [(NUM_WR+1)*AW-1:0] bsy_addr;
    logic [NUM_WR:0]          bsy_val;

    assign bsy_en   = {bus.busy_set, bus.wr_en};
    assign bsy_addr = {bus.busy_addr, bus.wr_addr};
    assign bsy_val  = {1'b1, {NUM_WR{1'b0}}};

    // Array next state: ascending port order so the highest port wins a collision.
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            mem_d[r] = mem_q[r];
        end
        for (int k = 0; k < NUM_WR; k++) begin
            if (bus.wr_en[k] && (bus.wr_addr[k*AW +: AW] != ZERO_ADDR)) begin
                mem_d[bus.wr_addr[k*AW +: AW]] = bus.wr_data[k*DATA_W +: DATA_W];
            end
        end
    end

    // Busy next state: writes retire first, then a new load re-marks its target.
    always_comb begin
        busy_d = busy_q;
        for (int k = 0; k < NUM_WR; k++) begin
            if (bus.wr_en[k]) begin
                busy_d[bus.wr_addr[k*AW +: AW]] = 1'b0;
            end
        end
        if (bus.busy_set && (bus.busy_addr != ZERO_ADDR)) begin
            busy_d[bus.busy_addr] = 1'b1;
        end
        busy_d[ZERO_IDX] = 1'b0;
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [AW-1:0] ra;
        assign ra = bus.rd_addr[p*AW +: AW];

        regfile_bypass_mux #(
            .W(DATA_W), .AW(AW), .NP(NUM_WR), .ZERO_IDX(ZERO_IDX)
        ) u_data_byp (
            .rd_addr (ra),
            .wr_en   (bus.wr_en),
            .wr_addr (bus.wr_addr),
            .wr_data (bus.wr_data),
            .arr_val (mem_q[ra]),
            .val     (byp_data[p])
        );

        regfile_bypass_mux #(
            .W(1), .AW(AW), .NP(NUM_WR + 1), .ZERO_IDX(ZERO_IDX)
        ) u_busy_byp (
            .rd_addr (ra),
            .wr_en   (bsy_en),
            .wr_addr (bsy_addr),
            .wr_data (bsy_val),
            .arr_val (busy_q[ra]),
            .val     (byp_busy[p])
        );
    end

    // Read capture: enabled ports load the bypassed value, others hold.
    always_comb begin
        rd_data_d = rd_data_q;
        rd_busy_d = rd_busy_q;
        for (int p = 0; p < NUM_RD; p++) begin
            if (bus.rd_en[p]) begin
                rd_data_d[p*DATA_W +: DATA_W] = byp_data[p];
                rd_busy_d[p]                  = byp_busy[p];
            end
        end
    end

    // All state, asynchronously reset; the array optionally resets to its own index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                mem_q[r] <= ((RESET_INDEX != 0) && (r != ZERO_IDX)) ? DATA_W'(r) : '0;
            end
            busy_q    <= '0;
            rd_data_q <= '0;
            rd_busy_q <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                mem_q[r] <= mem_d[r];
            end
            busy_q    <= busy_d;
            rd_data_q <= rd_data_d;
            rd_busy_q <= rd_busy_d;
        end
    end

    assign bus.rd_data = rd_data_q;
    assign bus.rd_busy = rd_busy_q;

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port register file for the LEGv8 datapath. It generalises the single-write, two-read register file.
- Adds configurable read/write port counts, synchronous writes, registered reads with write-to-read bypass, and a hardwired zero register at index NUM_REGS-1 (XZR).
- Adds a per-register busy scoreboard so multi-cycle producers (loads) can mark destinations pending.
- Sits between decode and execute; write ports are fed by ALU and memory writeback.

Parameters:
- DATA_W, 64, register width in bits.
- NUM_REGS, 32, number of registers (power of 2, >=4); index NUM_REGS-1 reads as zero and ignores writes.
- NUM_RD, 2, number of read ports (1..4).
- NUM_WR, 1, number of write ports (1..2); a higher port index has higher priority on an address collision.
- RESET_INDEX, 1, if 1 register r resets to value r (XZR to 0); if 0 all registers reset to 0.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- wr_en  in  NUM_WR  per-port write enable.
- wr_addr  in  NUM_WR*AW  per-port write index; AW = clog2(NUM_REGS); port k occupies bits [k*AW +: AW].
- wr_data  in  NUM_WR*DATA_W  per-port write data.
- rd_en  in  NUM_RD  per-port read enable; rd_data holds its value when the enable is low.
- rd_addr  in  NUM_RD*AW  per-port read index.
- rd_data  out  NUM_RD*DATA_W  registered read data.
- rd_busy  out  NUM_RD  registered busy bit of the register read on that port.
- busy_set  in  1  mark busy_addr pending (load issued).
- busy_addr  in  AW  index to mark pending.

Behaviour:
- Reset (rst_n low, asynchronous):
  - Array loads per RESET_INDEX.
  - rd_data=0, rd_busy=0, all busy bits 0.
  - Held for as long as rst_n is low; a write in flight during reset is lost.
- Write (synchronous): on a clk rising edge with wr_en[k]=1 and wr_addr[k]!=NUM_REGS-1, the array entry takes wr_data[k].
  - Writes to NUM_REGS-1 are dropped silently.
  - If two enabled ports target the same address, port NUM_WR-1 wins.
- Read (1-cycle latency): on a clk edge with rd_en[p]=1, rd_data[p] captures the selected value, which is resolved in this order:
  - rd_addr[p]==NUM_REGS-1 -> 0.
  - Else, a same-edge enabled write to rd_addr[p] -> that write's data (highest-priority port); this is the write-first bypass.
  - Else the array contents.
- Busy scoreboard (one bit per register):
  - Set on an edge with busy_set=1, for busy_addr!=NUM_REGS-1.
  - Cleared on an edge with an enabled write to that index.
  - Set and clear of the same index on the same edge: set wins. The new load is outstanding; the write retires an older producer.
  - The busy bit of XZR is constant 0.
- rd_busy[p]: captured alongside rd_data[p], using the same-edge busy value after the update above (bypassed).
- Multiple read ports may read the same address; reads never conflict.
- Addresses are always in range by construction; no out-of-range handling.
- No combinational path from any input to any output.

Decomposition:
- Shared package regfile_pkg holds:
  - constants XZR_IDX, DEFAULT_DATA_W=64, DEFAULT_NUM_REGS=32;
  - function clog2;
  - typedef reg_idx_t (logic [4:0]).
- One natural sub-module, regfile_bypass_mux: per read port, resolves zero / highest-priority same-edge write / array. It is instantiated NUM_RD times and reused for the busy bypass.

Test Plan:
1. Reset, RESET_INDEX=1: deassert rst_n; read r5 and r31 -> rd_data 5 and 0 next cycle; rd_busy 0.
2. Write r3=0xDEAD_BEEF with rd_addr[0]=3 on the same edge -> rd_data[0]=0xDEADBEEF after one cycle (bypass). A read of r3 on the following cycle returns the same value.
3. Write r31=0x1234, then read r31 -> rd_data 0; the array is unchanged.
4. NUM_WR=2, both ports write r7 (port0=0x11, port1=0x22) on one edge -> a read of r7 returns 0x22, including via the bypass.
5. busy_set r9, then read r9 -> rd_busy=1. Write r9=0x55 -> the next read gives rd_busy=0, data 0x55. busy_set and a write to r9 on the same edge -> busy stays 1.
6. Assert rst_n mid-cycle with wr_en high to r4=0xFF -> outputs go to 0 immediately (asynchronous); after release, r4 reads 4.
